// File: rtl/input_event_capture.sv
// input_event_capture
//   Per-frame input event engine for up to PLAYERS controllers. A sample strobe
//   snapshots every joystick word. The players are then scanned in order, one per
//   cycle. Each player whose state differs from the last delivered state queues a
//   {player, new state, change mask} event in a first-word-fall-through FIFO.
//   Independently, per-player spinner deltas are accumulated into wrapped
//   position counters.
//
// Ports
//   clk_sys      system clock (single domain)
//   reset        synchronous active-high reset
//   sample       one-cycle frame strobe; starts a snapshot + scan
//   joystick     PLAYERS*BTN_W joystick words, player p at [p*BTN_W +: BTN_W]
//   spinner      PLAYERS*9 spinner lanes, [p*9+8]=toggle, [p*9 +: 8]=signed delta
//   evt_valid    FIFO head is valid
//   evt_ready    consumer accepts the head entry
//   evt_player   head entry player index
//   evt_buttons  head entry new joystick state
//   evt_changed  head entry change mask vs previously delivered state
//   fifo_count   entries held, 0..DEPTH
//   spin_pos     PLAYERS*SPIN_W wrapped spinner positions
//   err          sticky: [0]=event dropped on full FIFO, [1]=sample during scan
//   err_clr      clears err; a simultaneous set wins
module input_event_capture #(
  parameter int PLAYERS = 6,
  parameter int BTN_W   = 32,
  parameter int DEPTH   = 16,
  parameter int SPIN_W  = 16,
  localparam int PW = (PLAYERS > 1) ? $clog2(PLAYERS) : 1,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic                      clk_sys,
  input  logic                      reset,
  input  logic                      sample,
  input  logic [PLAYERS*BTN_W-1:0]  joystick,
  input  logic [PLAYERS*9-1:0]      spinner,
  output logic                      evt_valid,
  input  logic                      evt_ready,
  output logic [PW-1:0]             evt_player,
  output logic [BTN_W-1:0]          evt_buttons,
  output logic [BTN_W-1:0]          evt_changed,
  output logic [CW-1:0]             fifo_count,
  output logic [PLAYERS*SPIN_W-1:0] spin_pos,
  output logic [1:0]                err,
  input  logic                      err_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = PW + 2 * BTN_W;

  typedef enum logic {S_IDLE, S_SCAN} state_t;

  state_t                        r_state;
  state_t                        w_state_next;
  logic                          w_scanning;
  logic                          w_latch;
  logic                          w_missed;

  logic [PW-1:0]                 r_idx;
  logic [PLAYERS-1:0][BTN_W-1:0] r_snap;
  logic [PLAYERS-1:0][BTN_W-1:0] r_prev;
  logic [BTN_W-1:0]              w_snap_cur;
  logic [BTN_W-1:0]              w_delta;

  logic [EW-1:0]                 r_mem [DEPTH];
  logic [AW-1:0]                 r_wr_ptr;
  logic [AW-1:0]                 r_rd_ptr;
  logic [CW-1:0]                 r_count;
  logic [EW-1:0]                 w_head;
  logic                          w_pop;
  logic                          w_full;
  logic                          w_push_req;
  logic                          w_push;
  logic                          w_drop;
  logic [1:0]                    r_err;
  logic                          r_spin_load;

  // ---------------- FSM ----------------
  always_ff @(posedge clk_sys) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (sample) w_state_next = S_SCAN;
      S_SCAN:  if (r_idx == PW'(PLAYERS - 1)) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_scanning = (r_state == S_SCAN);
    w_latch    = (r_state == S_IDLE) && sample;
    w_missed   = (r_state == S_SCAN) && sample;
  end

  // ---------------- scan datapath ----------------
  assign w_snap_cur = r_snap[r_idx];
  assign w_delta    = w_snap_cur ^ r_prev[r_idx];

  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign w_pop      = evt_valid && evt_ready;
  assign w_full     = (r_count == CW'(DEPTH));
  assign w_push_req = w_scanning && (w_delta != '0);
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_drop     = w_push_req && !w_push;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_idx  <= '0;
      r_snap <= '0;
    end else if (w_latch) begin
      r_idx  <= '0;
      r_snap <= joystick;
    end else if (w_scanning) begin
      r_idx  <= r_idx + PW'(1);
    end
  end

  // prev only advances when the event really made it into the FIFO, so a
  // dropped change is reported again against the last delivered state.
  always_ff @(posedge clk_sys) begin
    if (reset)       r_prev <= '0;
    else if (w_push) r_prev[r_idx] <= w_snap_cur;
  end

  // ---------------- event FIFO ----------------
  always_ff @(posedge clk_sys) begin
    if (w_push) r_mem[r_wr_ptr] <= {r_idx, w_snap_cur, w_delta};
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Head is read straight from the array; outputs are forced to zero when
  // empty so stale or uninitialised entries never show.
  assign w_head      = r_mem[r_rd_ptr];
  assign evt_valid   = (r_count != '0);
  assign fifo_count  = r_count;
  assign evt_player  = evt_valid ? w_head[2*BTN_W +: PW]  : '0;
  assign evt_buttons = evt_valid ? w_head[BTN_W +: BTN_W] : '0;
  assign evt_changed = evt_valid ? w_head[0 +: BTN_W]     : '0;

  // ---------------- sticky errors ----------------
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_err <= '0;
    end else begin
      r_err[0] <= w_drop   ? 1'b1 : (err_clr ? 1'b0 : r_err[0]);
      r_err[1] <= w_missed ? 1'b1 : (err_clr ? 1'b0 : r_err[1]);
    end
  end
  assign err = r_err;

  // ---------------- spinners ----------------
  // First edge out of reset only captures the toggle levels.
  always_ff @(posedge clk_sys) begin
    if (reset) r_spin_load <= 1'b1;
    else       r_spin_load <= 1'b0;
  end

  generate
    for (genvar gi = 0; gi < PLAYERS; gi++) begin : g_spin
      logic              w_tog;
      logic [7:0]        w_d8;
      logic              r_last_tog;
      logic [SPIN_W-1:0] r_pos;

      assign w_tog = spinner[gi*9 + 8];
      assign w_d8  = spinner[gi*9 +: 8];

      always_ff @(posedge clk_sys) begin
        if (reset) begin
          r_pos      <= '0;
          r_last_tog <= 1'b0;
        end else if (r_spin_load) begin
          r_last_tog <= w_tog;
        end else if (w_tog != r_last_tog) begin
          r_pos      <= r_pos + {{(SPIN_W-8){w_d8[7]}}, w_d8};
          r_last_tog <= w_tog;
        end
      end

      assign spin_pos[gi*SPIN_W +: SPIN_W] = r_pos;
    end
  endgenerate

endmodule

// File: tb/tb_input_event_capture.sv
module tb_input_event_capture;

  localparam int P  = 6;
  localparam int BW = 32;
  localparam int D  = 4;
  localparam int SW = 16;
  localparam int PW = 3;
  localparam int CW = 3;

  logic              clk_sys = 1'b0;
  logic              reset;
  logic              sample;
  logic [P*BW-1:0]   joystick;
  logic [P*9-1:0]    spinner;
  logic              evt_valid;
  logic              evt_ready;
  logic [PW-1:0]     evt_player;
  logic [BW-1:0]     evt_buttons;
  logic [BW-1:0]     evt_changed;
  logic [CW-1:0]     fifo_count;
  logic [P*SW-1:0]   spin_pos;
  logic [1:0]        err;
  logic              err_clr;

  always #5 clk_sys = ~clk_sys;

  input_event_capture #(.PLAYERS(P), .BTN_W(BW), .DEPTH(D), .SPIN_W(SW)) dut (
    .clk_sys(clk_sys), .reset(reset), .sample(sample), .joystick(joystick),
    .spinner(spinner), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_player(evt_player), .evt_buttons(evt_buttons), .evt_changed(evt_changed),
    .fifo_count(fifo_count), .spin_pos(spin_pos), .err(err), .err_clr(err_clr)
  );

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [PW-1:0] player;
    logic [BW-1:0] buttons;
    logic [BW-1:0] changed;
  } evt_t;

  evt_t          m_q[$];
  logic [BW-1:0] m_prev [P];
  logic [BW-1:0] m_snap [P];
  bit            m_scan;
  int            m_idx;
  logic [SW-1:0] m_spin [P];
  bit            m_tog [P];
  bit            m_first;
  logic [1:0]    m_err;

  int checks = 0;
  int errors = 0;

  // Advance the model across one clock edge using the inputs currently driven.
  task automatic model_edge();
    bit   pop, drop, missed;
    evt_t e;
    bit   do_push;
    logic [BW-1:0] d;
    if (reset) begin
      m_q.delete();
      for (int p = 0; p < P; p++) begin
        m_prev[p] = '0; m_snap[p] = '0; m_spin[p] = '0; m_tog[p] = 1'b0;
      end
      m_scan = 0; m_idx = 0; m_first = 1; m_err = '0;
      return;
    end
    pop = (m_q.size() != 0) && evt_ready;
    drop = 0; do_push = 0;
    missed = sample && m_scan;
    if (m_scan) begin
      d = m_snap[m_idx] ^ m_prev[m_idx];
      if (d != 0) begin
        if (m_q.size() < D || pop) begin
          e.player = PW'(m_idx); e.buttons = m_snap[m_idx]; e.changed = d;
          do_push = 1;
          m_prev[m_idx] = m_snap[m_idx];
        end else begin
          drop = 1;
        end
      end
    end
    if (pop) void'(m_q.pop_front());
    if (do_push) m_q.push_back(e);
    m_err[0] = drop   ? 1'b1 : (err_clr ? 1'b0 : m_err[0]);
    m_err[1] = missed ? 1'b1 : (err_clr ? 1'b0 : m_err[1]);
    if (m_scan) begin
      if (m_idx == P - 1) m_scan = 0;
      else m_idx++;
    end else if (sample) begin
      for (int p = 0; p < P; p++) m_snap[p] = joystick[p*BW +: BW];
      m_idx = 0; m_scan = 1;
    end
    for (int p = 0; p < P; p++) begin
      if (m_first) m_tog[p] = spinner[p*9+8];
      else if (spinner[p*9+8] != m_tog[p]) begin
        m_spin[p] = m_spin[p] + SW'(signed'(spinner[p*9 +: 8]));
        m_tog[p]  = spinner[p*9+8];
      end
    end
    m_first = 0;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    evt_t h;
    h = (m_q.size() != 0) ? m_q[0] : '0;
    chk("evt_valid", 64'(evt_valid), 64'(m_q.size() != 0));
    chk("fifo_count", 64'(fifo_count), 64'(m_q.size()));
    chk("evt_player", 64'(evt_player), 64'(h.player));
    chk("evt_buttons", 64'(evt_buttons), 64'(h.buttons));
    chk("evt_changed", 64'(evt_changed), 64'(h.changed));
    chk("err", 64'(err), 64'(m_err));
    for (int p = 0; p < P; p++)
      chk($sformatf("spin_pos[%0d]", p), 64'(spin_pos[p*SW +: SW]), 64'(m_spin[p]));
  endtask

  int cyc = 0;
  task automatic tick();
    model_edge();
    @(posedge clk_sys);
    #1;
    cyc++;
    check_all();
    $display("cyc %0d: sample=%0b rdy=%0b valid=%0b cnt=%0d head={%0d,%h,%h} err=%b",
             cyc, sample, evt_ready, evt_valid, fifo_count, evt_player, evt_buttons,
             evt_changed, err);
  endtask

  task automatic set_joy(input int p, input logic [BW-1:0] v);
    joystick[p*BW +: BW] = v;
  endtask

  task automatic set_spin(input int p, input logic tog, input logic [7:0] dl);
    spinner[p*9 +: 9] = {tog, dl};
  endtask

  // Pulse sample, then let the whole scan run.
  task automatic run_scan();
    sample = 1'b1; tick(); sample = 1'b0;
    repeat (P) tick();
  endtask

  task automatic head_is(input string tag, input int pl, input logic [BW-1:0] b,
                         input logic [BW-1:0] c);
    chk({tag, "_valid"}, 64'(evt_valid), 64'd1);
    chk({tag, "_player"}, 64'(evt_player), 64'(pl));
    chk({tag, "_buttons"}, 64'(evt_buttons), 64'(b));
    chk({tag, "_changed"}, 64'(evt_changed), 64'(c));
  endtask

  initial begin
    reset = 1'b1; sample = 1'b0; joystick = '0; spinner = '0;
    evt_ready = 1'b0; err_clr = 1'b0;
    repeat (2) tick();
    chk("rst_count", 64'(fifo_count), 64'd0);
    chk("rst_valid", 64'(evt_valid), 64'd0);
    chk("rst_spin", 64'(spin_pos), 64'd0);
    reset = 1'b0;
    repeat (2) tick();

    // 1. event ordering and latency
    set_joy(0, 32'h0001); set_joy(3, 32'h0300);
    sample = 1'b1; tick(); sample = 1'b0;
    chk("t1_T+1_valid", 64'(evt_valid), 64'd0);
    tick();
    head_is("t1_T+2", 0, 32'h0001, 32'h0001);
    repeat (P - 1) tick();
    chk("t1_count", 64'(fifo_count), 64'd2);
    chk("t1_err", 64'(err), 64'd0);
    evt_ready = 1'b1; tick();
    head_is("t1_second", 3, 32'h0300, 32'h0300);
    tick(); evt_ready = 1'b0;
    chk("t1_drained", 64'(fifo_count), 64'd0);

    // 2. change mask, then an unchanged sample
    set_joy(0, 32'h0003);
    run_scan();
    chk("t2_count", 64'(fifo_count), 64'd1);
    head_is("t2_evt", 0, 32'h0003, 32'h0002);
    evt_ready = 1'b1; tick(); evt_ready = 1'b0;
    run_scan();
    chk("t2_nochange", 64'(fifo_count), 64'd0);

    // 3. overflow: five changes into a four-deep FIFO, last one dropped
    set_joy(0, 32'h10); set_joy(1, 32'h20); set_joy(2, 32'h40);
    set_joy(3, 32'h80); set_joy(4, 32'h100);
    run_scan();
    chk("t3_full", 64'(fifo_count), 64'(D));
    chk("t3_err0", 64'(err[0]), 64'd1);
    head_is("t3_head", 0, 32'h10, 32'h13);
    evt_ready = 1'b1; repeat (D) tick(); evt_ready = 1'b0;
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    set_joy(4, 32'h101);
    run_scan();
    chk("t3_redeliver_cnt", 64'(fifo_count), 64'd1);
    head_is("t3_redeliver", 4, 32'h101, 32'h101);
    evt_ready = 1'b1; tick(); evt_ready = 1'b0;

    // 4. missed sample: the second strobe must not relatch joystick
    set_joy(5, 32'h5);
    sample = 1'b1; tick(); sample = 1'b0; tick();
    set_joy(1, 32'h21);
    sample = 1'b1; tick(); sample = 1'b0;
    chk("t4_err1", 64'(err[1]), 64'd1);
    repeat (P) tick();
    chk("t4_one_evt", 64'(fifo_count), 64'd1);
    head_is("t4_evt", 5, 32'h5, 32'h5);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("t4_clr", 64'(err), 64'd0);
    evt_ready = 1'b1; tick(); evt_ready = 1'b0;

    // 5. spinner accumulation and wrap
    set_spin(1, 1'b1, 8'h05); tick();
    chk("t5_pos5", 64'(spin_pos[SW +: SW]), 64'h5);
    set_spin(1, 1'b0, 8'hF9); tick();
    chk("t5_posFFFE", 64'(spin_pos[SW +: SW]), 64'hFFFE);
    tick();
    chk("t5_hold", 64'(spin_pos[SW +: SW]), 64'hFFFE);
    set_spin(1, 1'b1, 8'h03);
    reset = 1'b1; repeat (2) tick(); reset = 1'b0;
    repeat (3) tick();
    chk("t5_rst_tog", 64'(spin_pos), 64'd0);

    // 6. reset mid-scan with three events queued
    joystick = '0;
    set_joy(0, 32'h1); set_joy(1, 32'h2); set_joy(2, 32'h4);
    sample = 1'b1; tick(); sample = 1'b0;
    repeat (3) tick();
    chk("t6_queued", 64'(fifo_count), 64'd3);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("t6_count0", 64'(fifo_count), 64'd0);
    chk("t6_valid0", 64'(evt_valid), 64'd0);
    tick();
    run_scan();
    chk("t6_idle_err", 64'(err), 64'd0);
    chk("t6_rereport", 64'(fifo_count), 64'd3);
    head_is("t6_first", 0, 32'h1, 32'h1);
    evt_ready = 1'b1; repeat (3) tick(); evt_ready = 1'b0;

    // randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      for (int p = 0; p < P; p++) begin
        if ($urandom_range(5) == 0) set_joy(p, 32'($urandom_range(0, 7)) << (4 * p));
        if ($urandom_range(2) == 0) set_spin(p, ~spinner[p*9+8], 8'($urandom));
      end
      sample    = ($urandom_range(5) == 0);
      evt_ready = ($urandom_range(2) != 0);
      err_clr   = ($urandom_range(19) == 0);
      reset     = ($urandom_range(149) == 0);
      tick();
    end
    reset = 1'b0; sample = 1'b0; evt_ready = 1'b0; err_clr = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
